mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RV, default 32, meaning core data width (only 32 supported).
REQ-002 SHALL have parameter VA, default 32, meaning virtual address width.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have core-side ports:
- ifetch  in  1  fetch request, level, held until idone.
- pc  in  VA-1  halfword fetch address [VA-1:1].
- addr  in  VA-2  word data address [VA-1:2].
- rstrobe  in  2  data read request; any bit set = read.
- wmask  in  4  byte write enables; nonzero = write.
- wdata  in  32  write data.
- io_access  in  1  request targets I/O space.
- idone / rdone / wdone  out  1 each  one-cycle completion pulses.
- rdata  out  32  read word, valid with rdone.
- idata  out  16  instruction parcel, valid with idone.
REQ-005 SHALL have external byte-bus ports:
- ext_addr  out  VA  byte address.
- ext_wdata  out  8  write byte.
- ext_rdata  in  8  read byte, sampled at the end of each byte slot.
- ext_cs / ext_io_cs / ext_oe / ext_we  out  1 each  strobes.

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, READ, WRITE, DONE.
REQ-007 In IDLE, nonzero wmask SHALL start WRITE; else nonzero rstrobe SHALL start READ; else ifetch SHALL start FETCH (data has priority over fetch).
REQ-008 READ SHALL run 4 byte slots at addr*4+0..3, little-endian, assembling rdata[8i+7:8i].
REQ-009 FETCH SHALL run 2 byte slots at pc*2+0..1, assembling idata.
REQ-010 WRITE SHALL visit byte lanes 0..3 in order and skip lanes whose wmask bit is 0 (zero cycles spent on a skipped lane).
REQ-011 Each byte slot SHALL last 1+W cycles, where W is the wait count (see Configuration); ext_we SHALL be high only in the last cycle of a write slot.
REQ-012 ext_io_cs SHALL replace ext_cs when the request started with io_access=1; request inputs SHALL be latched at the start of the request and ignored until DONE.
REQ-013 DONE SHALL last exactly one cycle, pulse exactly one of idone/rdone/wdone, then return to IDLE; IDLE SHALL ignore requests during that cycle's follow-on edge (the core drops the request on the done edge).
REQ-014 Read latency with W=0 SHALL be 4 slot cycles + 1 DONE cycle; fetch 2+1; write (popcount wmask)+1.
REQ-015 rdata and idata SHALL hold their last values until the next completion of the same type.
REQ-016 Simultaneous wmask and rstrobe SHALL be treated as a write only.

Reset
REQ-017 Asserting reset_n low SHALL, asynchronously, force IDLE and drive all done pulses, strobes, ext_addr and ext_wdata to 0 and rdata/idata to 0, including mid-transfer. No partial completion SHALL be signalled.

Configuration
REQ-018 With MEM_WAIT_EN defined, the block SHALL add input wait_cfg[2:0] and per-slot wait count W=wait_cfg, sampled at request start; I/O requests SHALL use W=7 regardless.
REQ-019 Without MEM_WAIT_EN, the port SHALL be absent and W SHALL be 0.

Structure
REQ-020 The state enum, byte-lane count (4), fetch lane count (2) and the I/O wait constant (7) SHALL live in shared package vc32_mem_pkg.
REQ-021 One sub-module, mem_slot_timer (wait-state down-counter issuing a slot-end strobe), SHALL be used; all else flat.

Verification
REQ-022 Read: addr=0x40, ext memory bytes 0x100..0x103 = 11 22 33 44, W=0 -> rdone on the 5th cycle after request, rdata=0x44332211.
REQ-023 Write: wmask=4'b1010, wdata=0xAABBCCDD, addr=0x10 -> exactly two ext_we pulses, at 0x41=0xCC and 0x43=0xAA; wdone on the 3rd cycle.
REQ-024 Fetch: pc=0x81, bytes 0x102/0x103 = 0x34/0x12 -> idata=0x1234, idone on the 3rd cycle.
REQ-025 Priority: ifetch and rstrobe raised together -> READ completes first, then FETCH; no overlap of strobes.
REQ-026 I/O and wait states (MEM_WAIT_EN, wait_cfg=2): a memory read takes 4*3+1=13 cycles; an io_access read takes 4*8+1=33 cycles with ext_io_cs only.
REQ-027 Reset mid-write: reset_n low during lane 1 -> all outputs are 0 immediately, no wdone; after release, a new write completes normally.

Source files
------------

// File: rtl/vc32_mem_pkg.sv
// ---------------------------------------------------------------------------
// vc32_mem_pkg
// Shared definitions for the byte-serial memory responder:
//   - memState_e   : responder FSM states
//   - BYTE_LANES   : byte slots in a data word
//   - FETCH_LANES  : byte slots in an instruction parcel
//   - IO_WAIT      : fixed per-slot wait count applied to I/O space requests
//   - nextLane()   : finds the next enabled write lane at or above a start lane
// ---------------------------------------------------------------------------
package vc32_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } memState_e;

  localparam int         BYTE_LANES  = 4;
  localparam int         FETCH_LANES = 2;
  localparam logic [2:0] IO_WAIT     = 3'd7;

  // Returns the lowest lane index >= from whose mask bit is set.
  // Bit 2 of the result flags "no such lane" (value 4).
  function automatic logic [2:0] nextLane(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] sel;
    sel = 3'd4;
    for (int i = BYTE_LANES - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) begin
        sel = 3'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Bundles the core-side request/response signals and the external byte bus
// of the memory responder.
//   Core side  : ifetch, pc, addr, rstrobe, wmask, wdata, io_access (requests)
//                idone, rdone, wdone, rdata, idata (responses)
//   Byte bus   : ext_addr, ext_wdata, ext_cs, ext_io_cs, ext_oe, ext_we (out)
//                ext_rdata (in)
// Modports:
//   slave  - the responder
//   master - the core plus external memory (the environment)
// ---------------------------------------------------------------------------
interface mem_responder_if #(
  parameter int VA = 32
);

  logic          ifetch;
  logic [VA-1:1] pc;
  logic [VA-1:2] addr;
  logic [1:0]    rstrobe;
  logic [3:0]    wmask;
  logic [31:0]   wdata;
  logic          io_access;

  logic          idone;
  logic          rdone;
  logic          wdone;
  logic [31:0]   rdata;
  logic [15:0]   idata;

  logic [VA-1:0] ext_addr;
  logic [7:0]    ext_wdata;
  logic [7:0]    ext_rdata;
  logic          ext_cs;
  logic          ext_io_cs;
  logic          ext_oe;
  logic          ext_we;

  modport slave (
    input  ifetch, pc, addr, rstrobe, wmask, wdata, io_access, ext_rdata,
    output idone, rdone, wdone, rdata, idata,
           ext_addr, ext_wdata, ext_cs, ext_io_cs, ext_oe, ext_we
  );

  modport master (
    output ifetch, pc, addr, rstrobe, wmask, wdata, io_access, ext_rdata,
    input  idone, rdone, wdone, rdata, idata,
           ext_addr, ext_wdata, ext_cs, ext_io_cs, ext_oe, ext_we
  );

endinterface

// File: rtl/mem_slot_timer.sv
// ---------------------------------------------------------------------------
// mem_slot_timer
// Wait-state down-counter that paces byte slots. Each slot lasts wait_i+1
// cycles; slot_end_o marks the final cycle of a slot.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   load_i        - request start: preload the counter with wait_i
//   active_i      - a transfer is in progress
//   wait_i        - wait count for the next slot
//   slot_end_o    - high during the last cycle of the current slot
// ---------------------------------------------------------------------------
module mem_slot_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic       active_i,
  input  logic [2:0] wait_i,
  output logic       slot_end_o
);

  logic [2:0] cntQ;

  // Count down through the wait cycles of a slot, then reload so the
  // following slot (if any) starts with a full wait count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cntQ <= 3'd0;
    end else if (load_i) begin
      cntQ <= wait_i;
    end else if (active_i) begin
      if (cntQ == 3'd0) begin
        cntQ <= wait_i;
      end else begin
        cntQ <= cntQ - 3'd1;
      end
    end
  end

  assign slot_end_o = active_i && (cntQ == 3'd0);

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Serves 32-bit core data reads/writes and 16-bit instruction fetches over an
// 8-bit external bus, one byte per slot, little-endian. Data requests take
// priority over fetches; a write with any wmask bit set wins over a read.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   wait_cfg      - per-slot wait count (only with MEM_WAIT_EN)
//   bus           - mem_responder_if.slave (core side + byte bus)
// Configuration:
//   MEM_WAIT_EN   - when defined, adds wait_cfg; memory slots use wait_cfg
//                   wait cycles and I/O slots use IO_WAIT. Otherwise no waits.
// ---------------------------------------------------------------------------
module mem_responder
  import vc32_mem_pkg::*;
#(
  parameter int RV = 32,
  parameter int VA = 32
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef MEM_WAIT_EN
  input  logic [2:0] wait_cfg,
`endif
  mem_responder_if.slave bus
);

  memState_e     stateQ;
  memState_e     opQ;
  logic [1:0]    laneQ;
  logic [VA-1:2] addrQ;
  logic [VA-1:1] pcQ;
  logic [3:0]    wmaskQ;
  logic [31:0]   wdataQ;
  logic          ioQ;
  logic [2:0]    waitQ;
  logic [23:0]   bufQ;
  logic [RV-1:0] rdataQ;
  logic [15:0]   idataQ;

  logic          busy;
  logic          startReq;
  logic          slotEnd;
  logic [2:0]    waitStart;
  logic [2:0]    timerWait;
  logic [2:0]    firstLane;
  logic [2:0]    followLane;

  logic [VA-1:0] extAddr;
  logic [7:0]    extWdata;

  // Wait count a new request would use, fixed at request start.
`ifdef MEM_WAIT_EN
  assign waitStart = bus.io_access ? IO_WAIT : wait_cfg;
`else
  assign waitStart = 3'd0;
`endif

  assign busy      = (stateQ == FETCH) || (stateQ == READ) || (stateQ == WRITE);
  assign startReq  = (stateQ == IDLE) && ((|bus.wmask) || (|bus.rstrobe) || bus.ifetch);
  assign timerWait = (stateQ == IDLE) ? waitStart : waitQ;

  // Write lanes with a clear mask bit are skipped outright, so the lane
  // pointer jumps directly to the next enabled lane.
  assign firstLane  = nextLane(bus.wmask, 3'd0);
  assign followLane = nextLane(wmaskQ, {1'b0, laneQ} + 3'd1);

  mem_slot_timer uSlotTimer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (startReq),
    .active_i   (busy),
    .wait_i     (timerWait),
    .slot_end_o (slotEnd)
  );

  // Responder FSM. Request inputs are captured on every IDLE cycle, so the
  // values present on the starting edge are the ones used for the whole
  // transfer. DONE always returns to IDLE, which drops a request still held
  // across the completion edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= IDLE;
      opQ    <= IDLE;
      laneQ  <= 2'd0;
      addrQ  <= '0;
      pcQ    <= '0;
      wmaskQ <= 4'd0;
      wdataQ <= 32'd0;
      ioQ    <= 1'b0;
      waitQ  <= 3'd0;
      bufQ   <= 24'd0;
      rdataQ <= '0;
      idataQ <= 16'd0;
    end else begin
      case (stateQ)
        IDLE: begin
          addrQ  <= bus.addr;
          pcQ    <= bus.pc;
          wmaskQ <= bus.wmask;
          wdataQ <= bus.wdata;
          ioQ    <= bus.io_access;
          waitQ  <= waitStart;
          if (|bus.wmask) begin
            stateQ <= WRITE;
            opQ    <= WRITE;
            laneQ  <= firstLane[1:0];
          end else if (|bus.rstrobe) begin
            stateQ <= READ;
            opQ    <= READ;
            laneQ  <= 2'd0;
          end else if (bus.ifetch) begin
            stateQ <= FETCH;
            opQ    <= FETCH;
            laneQ  <= 2'd0;
          end
        end
        READ: begin
          if (slotEnd) begin
            case (laneQ)
              2'd0: bufQ[7:0]   <= bus.ext_rdata;
              2'd1: bufQ[15:8]  <= bus.ext_rdata;
              2'd2: bufQ[23:16] <= bus.ext_rdata;
              default: begin
                rdataQ <= {bus.ext_rdata, bufQ};
                stateQ <= DONE;
              end
            endcase
            laneQ <= laneQ + 2'd1;
          end
        end
        FETCH: begin
          if (slotEnd) begin
            if (laneQ == 2'(FETCH_LANES - 1)) begin
              idataQ <= {bus.ext_rdata, bufQ[7:0]};
              stateQ <= DONE;
            end else begin
              bufQ[7:0] <= bus.ext_rdata;
            end
            laneQ <= laneQ + 2'd1;
          end
        end
        WRITE: begin
          if (slotEnd) begin
            if (followLane[2]) begin
              stateQ <= DONE;
            end else begin
              laneQ <= followLane[1:0];
            end
          end
        end
        DONE: begin
          stateQ <= IDLE;
        end
        default: begin
          stateQ <= IDLE;
        end
      endcase
    end
  end

  // Byte bus address and write data follow the current lane; everything is
  // zero outside a transfer so reset clears the bus immediately.
  always_comb begin
    extAddr  = '0;
    extWdata = 8'd0;
    case (stateQ)
      READ:  extAddr = {addrQ, laneQ};
      FETCH: extAddr = {pcQ, laneQ[0]};
      WRITE: begin
        extAddr = {addrQ, laneQ};
        case (laneQ)
          2'd0:    extWdata = wdataQ[7:0];
          2'd1:    extWdata = wdataQ[15:8];
          2'd2:    extWdata = wdataQ[23:16];
          default: extWdata = wdataQ[31:24];
        endcase
      end
      default: begin
        extAddr  = '0;
        extWdata = 8'd0;
      end
    endcase
  end

  assign bus.ext_addr  = extAddr;
  assign bus.ext_wdata = extWdata;
  assign bus.ext_cs    = busy && !ioQ;
  assign bus.ext_io_cs = busy && ioQ;
  assign bus.ext_oe    = (stateQ == READ) || (stateQ == FETCH);
  assign bus.ext_we    = (stateQ == WRITE) && slotEnd;

  assign bus.rdone = (stateQ == DONE) && (opQ == READ);
  assign bus.wdone = (stateQ == DONE) && (opQ == WRITE);
  assign bus.idone = (stateQ == DONE) && (opQ == FETCH);
  assign bus.rdata = rdataQ;
  assign bus.idata = idataQ;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder. A byte-array model stands in for
// external memory; expected write bytes and read/fetch data are queued when a
// request is driven and popped when the responder completes.
// With MEM_WAIT_EN defined the wait-state scenarios are also run.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic reset_n;
`ifdef MEM_WAIT_EN
  logic [2:0] wait_cfg;
`endif

  mem_responder_if #(.VA(32)) bus ();

  mem_responder #(.RV(32), .VA(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef MEM_WAIT_EN
    .wait_cfg(wait_cfg),
`endif
    .bus     (bus.slave)
  );

  logic [7:0] mem [0:511];
  assign bus.ext_rdata = mem[bus.ext_addr[8:0]];

  int          vectors = 0;
  int          miscompares = 0;
  wr_t         expWr[$];
  wr_t         obsWr[$];
  logic [31:0] expData[$];
  int          doneAt;
  int          doneKind;
  logic        csSeen;
  logic        ioSeen;
  logic        clash;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quiet all core-side request inputs.
  task automatic applyStimulus();
    bus.ifetch    = 1'b0;
    bus.pc        = '0;
    bus.addr      = '0;
    bus.rstrobe   = 2'b00;
    bus.wmask     = 4'b0000;
    bus.wdata     = 32'd0;
    bus.io_access = 1'b0;
  endtask

  // Drop requests and let any DONE cycle drain back to IDLE.
  task automatic settle();
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Observe the bus until a completion pulse or the cycle budget runs out.
  // doneKind: bit0 rdone, bit1 wdone, bit2 idone; doneAt = -1 on timeout.
  task automatic runCycles(input int maxCycles);
    doneAt   = -1;
    doneKind = 0;
    csSeen   = 1'b0;
    ioSeen   = 1'b0;
    clash    = 1'b0;
    obsWr.delete();
    for (int n = 1; n <= maxCycles; n++) begin
      @(posedge clk);
      #1;
      if (bus.ext_cs) csSeen = 1'b1;
      if (bus.ext_io_cs) ioSeen = 1'b1;
      if (bus.ext_cs && bus.ext_io_cs) clash = 1'b1;
      if (bus.ext_we) obsWr.push_back({bus.ext_addr, 24'd0, bus.ext_wdata});
      if (bus.rdone || bus.wdone || bus.idone) begin
        doneKind = {29'd0, bus.idone, bus.wdone, bus.rdone};
        doneAt   = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    applyStimulus();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.ext_cs, bus.ext_io_cs, bus.ext_oe, bus.ext_we} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_strobes got %b want 0000", {bus.ext_cs, bus.ext_io_cs, bus.ext_oe, bus.ext_we});
    end
    vectors++;
    if ({bus.rdone, bus.wdone, bus.idone} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_done got %b want 000", {bus.rdone, bus.wdone, bus.idone});
    end
    vectors++;
    if ({bus.ext_addr, bus.ext_wdata, bus.rdata, bus.idata} !== 88'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data addr=%h wdata=%h rdata=%h idata=%h want 0", bus.ext_addr, bus.ext_wdata, bus.rdata, bus.idata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read();
    wr_t dummy;
    dummy = '0;
    settle();
    bus.addr    = 30'h40;
    bus.rstrobe = 2'b01;
    expData.push_back(32'h44332211);
    runCycles(100);
    applyStimulus();
    vectors++;
    if (doneAt !== 5 || doneKind !== 1) begin
      miscompares++;
      $display("[TB] FAIL read_latency got cycle %0d kind %0d want cycle 5 kind 1", doneAt, doneKind);
    end
    vectors++;
    if (bus.rdata !== expData.pop_front()) begin
      miscompares++;
      $display("[TB] FAIL read_data got %h want 44332211", bus.rdata);
    end
    vectors++;
    if (csSeen !== 1'b1 || ioSeen !== 1'b0 || obsWr.size() != 0 || dummy != '0) begin
      miscompares++;
      $display("[TB] FAIL read_strobes cs=%b io=%b writes=%0d want cs=1 io=0 writes=0", csSeen, ioSeen, obsWr.size());
    end
  endtask

  task automatic test_write();
    wr_t e;
    wr_t o;
    settle();
    bus.addr  = 30'h10;
    bus.wmask = 4'b1010;
    bus.wdata = 32'hAABBCCDD;
    expWr.push_back({32'h41, 32'hCC});
    expWr.push_back({32'h43, 32'hAA});
    runCycles(100);
    applyStimulus();
    vectors++;
    if (doneAt !== 3 || doneKind !== 2) begin
      miscompares++;
      $display("[TB] FAIL write_latency got cycle %0d kind %0d want cycle 3 kind 2", doneAt, doneKind);
    end
    vectors++;
    if (obsWr.size() != expWr.size()) begin
      miscompares++;
      $display("[TB] FAIL write_count got %0d want %0d", obsWr.size(), expWr.size());
    end
    while (expWr.size() > 0) begin
      e = expWr.pop_front();
      o = (obsWr.size() > 0) ? obsWr.pop_front() : '1;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL write_byte got %h=%h want %h=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    vectors++;
    if (bus.rdata !== 32'h44332211) begin
      miscompares++;
      $display("[TB] FAIL rdata_hold got %h want 44332211", bus.rdata);
    end
  endtask

  task automatic test_fetch();
    settle();
    bus.pc     = 31'h81;
    bus.ifetch = 1'b1;
    expData.push_back(32'h00001234);
    runCycles(100);
    applyStimulus();
    vectors++;
    if (doneAt !== 3 || doneKind !== 4) begin
      miscompares++;
      $display("[TB] FAIL fetch_latency got cycle %0d kind %0d want cycle 3 kind 4", doneAt, doneKind);
    end
    vectors++;
    if ({16'd0, bus.idata} !== expData.pop_front()) begin
      miscompares++;
      $display("[TB] FAIL fetch_data got %h want 1234", bus.idata);
    end
    vectors++;
    if (bus.rdata !== 32'h44332211) begin
      miscompares++;
      $display("[TB] FAIL fetch_rdata_hold got %h want 44332211", bus.rdata);
    end
  endtask

  task automatic test_priority();
    settle();
    bus.addr    = 30'h41;
    bus.rstrobe = 2'b10;
    bus.pc      = 31'h80;
    bus.ifetch  = 1'b1;
    expData.push_back(32'h88776655);
    expData.push_back(32'h0000BBAA);
    runCycles(100);
    bus.rstrobe = 2'b00;
    vectors++;
    if (doneAt !== 5 || doneKind !== 1 || bus.rdata !== expData.pop_front()) begin
      miscompares++;
      $display("[TB] FAIL priority_read got cycle %0d kind %0d rdata %h want cycle 5 kind 1 rdata 88776655", doneAt, doneKind, bus.rdata);
    end
    runCycles(100);
    applyStimulus();
    vectors++;
    if (doneAt !== 4 || doneKind !== 4 || {16'd0, bus.idata} !== expData.pop_front()) begin
      miscompares++;
      $display("[TB] FAIL priority_fetch got cycle %0d kind %0d idata %h want cycle 4 kind 4 idata bbaa", doneAt, doneKind, bus.idata);
    end
  endtask

  task automatic test_write_over_read();
    wr_t o;
    settle();
    bus.addr    = 30'h11;
    bus.wmask   = 4'b0001;
    bus.rstrobe = 2'b11;
    bus.wdata   = 32'h1234565A;
    runCycles(100);
    applyStimulus();
    o = (obsWr.size() == 1) ? obsWr.pop_front() : '1;
    vectors++;
    if (doneAt !== 2 || doneKind !== 2 || o !== {32'h44, 32'h5A}) begin
      miscompares++;
      $display("[TB] FAIL write_over_read got cycle %0d kind %0d byte %h=%h want cycle 2 kind 2 byte 44=5a", doneAt, doneKind, o.addr, o.data);
    end
  endtask

  task automatic test_io();
    int expLat;
`ifdef MEM_WAIT_EN
    expLat = 33;
`else
    expLat = 5;
`endif
    settle();
    bus.addr      = 30'h40;
    bus.rstrobe   = 2'b01;
    bus.io_access = 1'b1;
    runCycles(200);
    applyStimulus();
    vectors++;
    if (doneAt !== expLat || bus.rdata !== 32'h44332211) begin
      miscompares++;
      $display("[TB] FAIL io_read got cycle %0d rdata %h want cycle %0d rdata 44332211", doneAt, bus.rdata, expLat);
    end
    vectors++;
    if (ioSeen !== 1'b1 || csSeen !== 1'b0 || clash !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL io_select io=%b cs=%b both=%b want io=1 cs=0 both=0", ioSeen, csSeen, clash);
    end
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_wait_states();
    settle();
    wait_cfg    = 3'd2;
    bus.addr    = 30'h41;
    bus.rstrobe = 2'b01;
    runCycles(200);
    applyStimulus();
    vectors++;
    if (doneAt !== 13 || bus.rdata !== 32'h88776655) begin
      miscompares++;
      $display("[TB] FAIL wait_read got cycle %0d rdata %h want cycle 13 rdata 88776655", doneAt, bus.rdata);
    end
    settle();
    bus.addr  = 30'h50;
    bus.wmask = 4'b0110;
    bus.wdata = 32'h00C3B200;
    runCycles(200);
    applyStimulus();
    vectors++;
    if (doneAt !== 7 || obsWr.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL wait_write got cycle %0d pulses %0d want cycle 7 pulses 2", doneAt, obsWr.size());
    end
    test_io();
    wait_cfg = 3'd0;
  endtask
`endif

  task automatic test_reset_mid_write();
    wr_t o;
    int  wdoneSeen;
    settle();
    bus.addr  = 30'h20;
    bus.wmask = 4'b1111;
    bus.wdata = 32'h01020304;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.ext_cs, bus.ext_io_cs, bus.ext_oe, bus.ext_we, bus.wdone} !== 5'b00000 ||
        {bus.ext_addr, bus.ext_wdata, bus.rdata, bus.idata} !== 88'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_write cs=%b we=%b wdone=%b addr=%h wdata=%h rdata=%h idata=%h want all 0",
               bus.ext_cs, bus.ext_we, bus.wdone, bus.ext_addr, bus.ext_wdata, bus.rdata, bus.idata);
    end
    applyStimulus();
    wdoneSeen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.wdone) wdoneSeen++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.wdone) wdoneSeen++;
    end
    vectors++;
    if (wdoneSeen != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_wdone got %0d pulses want 0", wdoneSeen);
    end
    bus.addr  = 30'h30;
    bus.wmask = 4'b0100;
    bus.wdata = 32'h00EE0000;
    runCycles(100);
    applyStimulus();
    o = (obsWr.size() == 1) ? obsWr.pop_front() : '1;
    vectors++;
    if (doneAt !== 2 || doneKind !== 2 || o !== {32'hC2, 32'hEE}) begin
      miscompares++;
      $display("[TB] FAIL post_reset_write got cycle %0d kind %0d byte %h=%h want cycle 2 kind 2 byte c2=ee", doneAt, doneKind, o.addr, o.data);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i ^ 8'h5C);
    mem[9'h100] = 8'h11;
    mem[9'h101] = 8'h22;
    mem[9'h102] = 8'h33;
    mem[9'h103] = 8'h44;
    mem[9'h104] = 8'h55;
    mem[9'h105] = 8'h66;
    mem[9'h106] = 8'h77;
    mem[9'h107] = 8'h88;
    mem[9'h100] = 8'h11;
    mem[9'h102] = 8'h34;
    mem[9'h103] = 8'h12;
    reset_n = 1'b0;
`ifdef MEM_WAIT_EN
    wait_cfg = 3'd0;
`endif
    test_reset();
    mem[9'h102] = 8'h33;
    mem[9'h103] = 8'h44;
    test_read();
    test_write();
    mem[9'h102] = 8'h34;
    mem[9'h103] = 8'h12;
    test_fetch();
    mem[9'h100] = 8'hAA;
    mem[9'h101] = 8'hBB;
    test_priority();
    mem[9'h100] = 8'h11;
    mem[9'h101] = 8'h22;
    mem[9'h102] = 8'h33;
    mem[9'h103] = 8'h44;
    test_write_over_read();
`ifdef MEM_WAIT_EN
    test_wait_states();
`else
    test_io();
`endif
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
